// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter and sequencer in front of a simple-dual-port RAM.
// Define RAM_ARBITER_CLEAR_EN to compile in the RAM clear sequencer (CLEAR state).
module ram_arbiter #(
    parameter int ADDR_WIDTH          = 4,
    parameter int NUMBER_OF_ADDRESSES = 1 << ADDR_WIDTH,
    parameter int DATA_WIDTH          = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_write,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_write,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_write_en,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    input  logic                  clear_start,
    output logic                  clear_busy
);

    logic                  in_clear;
    logic [ADDR_WIDTH-1:0] clear_addr;
    logic                  grant_a;
    logic                  grant_b;
    logic                  grant_any;
    logic                  gnt_write;
    logic                  wr_grant;
    logic                  rd_grant;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [DATA_WIDTH-1:0] gnt_wdata;
    logic                  last_grant_q, last_grant_d;  // 1 = B was granted last
    logic                  rsp_a_q, rsp_a_d;
    logic                  rsp_b_q, rsp_b_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;

`ifdef RAM_ARBITER_CLEAR_EN
    typedef enum logic {ST_RUN = 1'b0, ST_CLEAR = 1'b1} state_t;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUMBER_OF_ADDRESSES - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    // clear_start is only looked at in RUN, so it can never restart a sweep
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            if (cnt_q == LAST_ADDR) begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (clear_start) begin
            state_d = ST_CLEAR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_clear   = (state_q == ST_CLEAR);
    assign clear_addr = cnt_q;
`else
    localparam int unused_words = NUMBER_OF_ADDRESSES;
    logic unused_clear_start;

    assign unused_clear_start = clear_start;
    assign in_clear           = 1'b0;
    assign clear_addr         = '0;
`endif

    always_comb begin
        grant_a   = !in_clear && a_valid && (!b_valid || last_grant_q);
        grant_b   = !in_clear && b_valid && !grant_a;
        grant_any = grant_a || grant_b;
        gnt_write = grant_a ? a_write : b_write;
        gnt_addr  = grant_a ? a_addr  : b_addr;
        gnt_wdata = grant_a ? a_wdata : b_wdata;
        wr_grant  = grant_any && gnt_write;
        rd_grant  = grant_any && !gnt_write;

        // RAM port values hold between accesses; the clear sweep wins the write port
        waddr_d = waddr_q;
        din_d   = din_q;
        raddr_d = raddr_q;
        if (in_clear) begin
            waddr_d = clear_addr;
            din_d   = '0;
        end else if (wr_grant) begin
            waddr_d = gnt_addr;
            din_d   = gnt_wdata;
        end
        if (rd_grant) begin
            raddr_d = gnt_addr;
        end

        last_grant_d = grant_a ? 1'b0 : (grant_b ? 1'b1 : last_grant_q);
        rsp_a_d      = rd_grant && grant_a;
        rsp_b_d      = rd_grant && grant_b;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            rsp_a_q      <= 1'b0;
            rsp_b_q      <= 1'b0;
            waddr_q      <= '0;
            raddr_q      <= '0;
            din_q        <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rsp_a_q      <= rsp_a_d;
            rsp_b_q      <= rsp_b_d;
            waddr_q      <= waddr_d;
            raddr_q      <= raddr_d;
            din_q        <= din_d;
        end
    end

    // While reset is high nothing is granted and the RAM ports show their reset values
    assign a_ready      = grant_a && !reset;
    assign b_ready      = grant_b && !reset;
    assign ram_write_en = (wr_grant || in_clear) && !reset;
    assign ram_waddr    = reset ? waddr_q : waddr_d;
    assign ram_din      = reset ? din_q   : din_d;
    assign ram_raddr    = reset ? raddr_q : raddr_d;

    assign a_rsp_valid = rsp_a_q;
    assign b_rsp_valid = rsp_b_q;
    assign a_rdata     = ram_dout;
    assign b_rdata     = ram_dout;
    assign clear_busy  = in_clear;

endmodule
